mvm_rx_packer: RTL

MVM_RX_PACKER -- requirements
Module: mvm_rx_packer

---
 rtl/mvm_rx_packer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mvm_rx_packer.sv
// Packs a host beat stream (H0, H1, H2, payload) into one wide MVM word plus tuser header.
// Optional feature: define MVM_RX_PACKER_INST_BYPASS_EN so op 2'b00 packets carry a single payload beat.
module mvm_rx_packer #(
  parameter int DATAW = 512,
  parameter int INW   = 32,
  parameter int USERW = 75
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [INW-1:0]   s_tdata,
  input  logic             s_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DATAW-1:0] m_tdata,
  output logic [USERW-1:0] m_tuser,
  output logic             m_tlast,
  output logic [7:0]       err_cnt
);

  localparam int BEATS = DATAW / INW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, PAY, DRAIN} state_t;

  state_t             r_state;
  logic               r_live;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic [8:0]         r_addr;
  logic [63:0]        r_mask;
  logic [DATAW-1:0]   r_data;
  logic               r_mvalid;
  logic [DATAW-1:0]   r_mdata;
  logic [USERW-1:0]   r_muser;
  logic [7:0]         r_err;

  logic               w_final;
  logic               w_stall;
  logic               w_fire;
  logic               w_load;
  logic               w_err;
  logic [31:0]        w_off;
  logic [DATAW-1:0]   w_word;
  logic [USERW-1:0]   w_user;

  always_comb begin
`ifdef MVM_RX_PACKER_INST_BYPASS_EN
    w_final = (r_op == 2'b00) || (r_cnt == LAST_IDX);
`else
    w_final = (r_cnt == LAST_IDX);
`endif
  end

  // Only the closing payload beat needs the output register; stall it while a word is still unread.
  assign w_stall  = (r_state == PAY) && w_final && r_mvalid && !m_tready;
  assign s_tready = r_live && !w_stall;
  assign w_fire   = s_tvalid && s_tready;
  assign w_load   = w_fire && (r_state == PAY) && w_final && s_tlast;
  assign w_off    = 32'(r_cnt) * INW;

  always_comb begin
    w_word = r_data;
    w_word[w_off +: INW] = s_tdata;
`ifdef MVM_RX_PACKER_INST_BYPASS_EN
    if (r_op == 2'b00) begin
      w_word = '0;
      w_word[INW-1:0] = s_tdata;
    end
`endif
  end

  always_comb begin
    w_user = '0;
    w_user[74:0] = {r_mask, r_op, r_addr};
  end

  always_comb begin
    w_err = 1'b0;
    if (w_fire) begin
      case (r_state)
        HDR0, HDR1, HDR2: w_err = s_tlast;
        PAY:              w_err = w_final ? !s_tlast : s_tlast;
        default:          w_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= HDR0;
      r_live   <= 1'b0;
      r_cnt    <= '0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_muser  <= '0;
      r_err    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_err && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      if (w_fire) begin
        case (r_state)
          HDR0: r_state <= s_tlast ? HDR0 : HDR1;
          HDR1: r_state <= s_tlast ? HDR0 : HDR2;
          HDR2: begin
            r_cnt   <= '0;
            r_state <= s_tlast ? HDR0 : PAY;
          end
          PAY: begin
            r_cnt <= r_cnt + CW'(1);
            if (w_final)      r_state <= s_tlast ? HDR0 : DRAIN;
            else if (s_tlast) r_state <= HDR0;
          end
          DRAIN: if (s_tlast) r_state <= HDR0;
          default: r_state <= HDR0;
        endcase
      end
      if (w_load) begin
        r_mvalid <= 1'b1;
        r_mdata  <= w_word;
        r_muser  <= w_user;
      end else if (m_tready) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  // Header and payload staging carry no reset; they are fully rewritten before use.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      case (r_state)
        HDR0: begin
          r_op   <= s_tdata[1:0];
          r_addr <= s_tdata[10:2];
        end
        HDR1:    r_mask[31:0]  <= s_tdata[31:0];
        HDR2:    r_mask[63:32] <= s_tdata[31:0];
        PAY:     r_data[w_off +: INW] <= s_tdata;
        default: ;
      endcase
    end
  end

  assign m_tvalid = r_mvalid;
  assign m_tdata  = r_mdata;
  assign m_tuser  = r_muser;
  assign m_tlast  = r_mvalid;
  assign err_cnt  = r_err;

endmodule
